// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM state encoding, special key codes,
// and the row/column to key-code map.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'h0;
        case ({row, col})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hE;
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Lowest-indexed active-low row wins when several rows are pulled down.
    function automatic logic [1:0] low_row(input logic [3:0] rows);
        logic [1:0] r;
        r = 2'd3;
        if (!rows[2]) r = 2'd2;
        if (!rows[1]) r = 2'd1;
        if (!rows[0]) r = 2'd0;
        return r;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and number-path signals of the scanner, plus the FSM state for observation.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [3:0] Filas;
    logic [3:0] Columnas;
    logic [3:0] Tecla;
    logic       TeclaValida;
    logic [7:0] Numero;
    logic       NumeroListo;
    state_t     scan_state;

    // TeclaValida and NumeroListo are single-cycle strobes with no back-pressure:
    // the consumer must take Tecla / Numero in the cycle the strobe is high.
    modport master (
        input  Filas,
        output Columnas, Tecla, TeclaValida, Numero, NumeroListo, scan_state
    );

    modport slave (
        output Filas,
        input  Columnas, Tecla, TeclaValida, Numero, NumeroListo, scan_state
    );
endinterface

// File: rtl/keypad_scanner_accum.sv
// Decimal entry accumulator: folds accepted key codes into an 8-bit saturating value.
module decimal_accumulator
    import keypad_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] key,
    input  logic       valid,
    output logic [7:0] Numero,
    output logic       NumeroListo
);

    logic        fresh;
    logic [11:0] prod;

    assign prod = 12'(Numero) * 12'd10 + 12'(key);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Numero      <= 8'd0;
            NumeroListo <= 1'b0;
            fresh       <= 1'b0;
        end else begin
            NumeroListo <= 1'b0;
            if (valid) begin
                if (key <= 4'd9) begin
                    // After ENTER the next digit starts a new number instead of appending.
                    if (fresh) begin
                        Numero <= {4'b0000, key};
                        fresh  <= 1'b0;
                    end else begin
                        Numero <= (prod > 12'd255) ? 8'hFF : prod[7:0];
                    end
                end else if (key == KEY_CLEAR) begin
                    Numero <= 8'd0;
                    fresh  <= 1'b0;
                end else if (key == KEY_ENTER) begin
                    NumeroListo <= 1'b1;
                    fresh       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and decimal accumulation.
// Define KEYPAD_AUTOREPEAT_EN to re-pulse TeclaValida while a key stays held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = 100_000,
    parameter int DEBOUNCE_TICKS = 500_000,
    parameter int REPEAT_DELAY   = 50_000_000,
    parameter int REPEAT_PERIOD  = 10_000_000
) (
    input  logic Clk,
    input  logic Rst,
    keypad_scanner_if.master kp
);

    localparam int SCAN_W   = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int MAX_A    = (DEBOUNCE_TICKS > REPEAT_DELAY) ? DEBOUNCE_TICKS : REPEAT_DELAY;
    localparam int MAX_T    = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CNT_W    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_TICKS - 1);
    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);

    state_t              state, state_n;
    logic [3:0]          fs_meta, fs;
    logic [SCAN_W-1:0]   scan_cnt, scan_cnt_n;
    // Debounce counter; while HELD it doubles as the auto-repeat timer.
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [1:0]          col, col_n;
    logic [3:0]          lat, lat_n;
    logic [3:0]          tecla, tecla_n;
    logic                valid, valid_n;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic                rep_first, rep_first_n;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            fs_meta <= 4'hF;
            fs      <= 4'hF;
        end else begin
            fs_meta <= kp.Filas;
            fs      <= fs_meta;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= SCAN;
            scan_cnt  <= '0;
            cnt       <= '0;
            col       <= 2'd0;
            lat       <= 4'hF;
            tecla     <= 4'h0;
            valid     <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_first <= 1'b1;
`endif
        end else begin
            state     <= state_n;
            scan_cnt  <= scan_cnt_n;
            cnt       <= cnt_n;
            col       <= col_n;
            lat       <= lat_n;
            tecla     <= tecla_n;
            valid     <= valid_n;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_first <= rep_first_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        scan_cnt_n  = scan_cnt;
        cnt_n       = cnt;
        col_n       = col;
        lat_n       = lat;
        tecla_n     = tecla;
        valid_n     = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_first_n = rep_first;
`endif
        case (state)
            SCAN: begin
                if (scan_cnt == SCAN_LAST) begin
                    scan_cnt_n = '0;
                    if (fs != 4'hF) begin
                        state_n = DEB_PRESS;
                        lat_n   = fs;
                        cnt_n   = '0;
                    end else begin
                        col_n = col + 2'd1;
                    end
                end else begin
                    scan_cnt_n = scan_cnt + SCAN_W'(1);
                end
            end
            DEB_PRESS: begin
                if (fs != lat) begin
                    state_n    = SCAN;
                    col_n      = col + 2'd1;
                    scan_cnt_n = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n     = HELD;
                    tecla_n     = keymap(low_row(lat), col);
                    valid_n     = 1'b1;
                    cnt_n       = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_first_n = 1'b1;
`endif
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (fs == 4'hF) begin
                    state_n = DEB_RELEASE;
                    cnt_n   = '0;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (cnt == (rep_first ? CNT_W'(REPEAT_DELAY - 1)
                                           : CNT_W'(REPEAT_PERIOD - 1))) begin
                    valid_n     = 1'b1;
                    cnt_n       = '0;
                    rep_first_n = 1'b0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
`endif
            end
            default: begin
                if (fs != 4'hF) begin
                    state_n     = HELD;
                    cnt_n       = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_first_n = 1'b1;
`endif
                end else if (cnt == DEB_LAST) begin
                    state_n    = SCAN;
                    col_n      = col + 2'd1;
                    scan_cnt_n = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    assign kp.Columnas    = ~(4'b0001 << col);
    assign kp.Tecla       = tecla;
    assign kp.TeclaValida = valid;
    assign kp.scan_state  = state;

    decimal_accumulator u_accum (
        .Clk         (Clk),
        .Rst         (Rst),
        .key         (tecla),
        .valid       (valid),
        .Numero      (kp.Numero),
        .NumeroListo (kp.NumeroListo)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives the rows, expected key/number
// results are queued per press and compared when TeclaValida fires.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_TICKS     (4),
    .DEBOUNCE_TICKS (8),
    .REPEAT_DELAY   (40),
    .REPEAT_PERIOD  (16)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .kp  (kif)
  );

  // Keypad model: a pressed key pulls its row low only while its column is strobed.
  logic       key_down = 1'b0;
  logic [1:0] key_row  = 2'd0;
  logic [1:0] key_col  = 2'd0;
  logic       glitch   = 1'b0;
  assign kif.Filas = glitch ? 4'b1101 :
                     (key_down && (kif.Columnas[key_col] == 1'b0)) ? ~(4'b0001 << key_row) : 4'hF;

  logic [3:0] km [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                            '{4'h4, 4'h5, 4'h6, 4'hB},
                            '{4'h7, 4'h8, 4'h9, 4'hC},
                            '{4'hE, 4'h0, 4'hF, 4'hD}};

  int checks    = 0;
  int errors    = 0;
  int pulse_cnt = 0;
  int listo_cnt = 0;
  int cycle     = 0;
  int pulse_cycle[$];

  // {key[3:0], numero[7:0], listo}
  logic [12:0] exp_q[$];
  logic [12:0] mon_e;
  logic [8:0]  exp_nl;
  logic        num_pending = 1'b0;

  always @(posedge Clk) cycle++;

  // Scoreboard: compare key code on the pulse, number path one cycle later.
  always @(negedge Clk) begin
    if (kif.NumeroListo) listo_cnt++;
    if (num_pending) begin
      num_pending = 1'b0;
      checks++;
      assert ({kif.Numero, kif.NumeroListo} === exp_nl) else begin
        errors++;
        $error("FAIL numero: got %0d listo %b, expected %0d listo %b",
               kif.Numero, kif.NumeroListo, exp_nl[8:1], exp_nl[0]);
      end
    end
    if (kif.TeclaValida) begin
      pulse_cnt++;
      pulse_cycle.push_back(cycle);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse: got Tecla %h, expected no pulse", kif.Tecla);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        assert (kif.Tecla === mon_e[12:9]) else begin
          errors++;
          $error("FAIL tecla: got %h expected %h", kif.Tecla, mon_e[12:9]);
        end
        exp_nl      = mon_e[8:0];
        num_pending = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] code, input int hold);
    int start;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (km[r][c] == code) begin
          key_row = 2'(r);
          key_col = 2'(c);
        end
    start    = pulse_cnt;
    key_down = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (pulse_cnt != start) break;
      @(posedge Clk);
    end
    check("press_accepted", 32'(pulse_cnt > start), 32'd1);
    repeat (hold) @(posedge Clk);
    key_down = 1'b0;
    repeat (24) @(posedge Clk);
  endtask

  task automatic key(input logic [3:0] code, input logic [7:0] num, input logic listo);
    exp_q.push_back({code, num, listo});
    press(code, 4);
  endtask

  initial begin
    logic [3:0] ec;
    logic [3:0] c0;
    int start;
    int base;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_columnas",    32'(kif.Columnas),    32'h0000000E);
    check("rst_tecla",       32'(kif.Tecla),       32'd0);
    check("rst_valid",       32'(kif.TeclaValida), 32'd0);
    check("rst_numero",      32'(kif.Numero),      32'd0);
    check("rst_listo",       32'(kif.NumeroListo), 32'd0);
    check("rst_state",       32'(kif.scan_state),  32'(SCAN));
    Rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      ec = ~(4'b0001 << ((i / 4) % 4));
      check("col_rotate", 32'(kif.Columnas), 32'(ec));
      @(negedge Clk);
    end

    key(4'h6, 8'd6, 1'b0);
    key(4'hE, 8'd0, 1'b0);
    key(4'h2, 8'd2, 1'b0);
    key(4'h5, 8'd25, 1'b0);
    key(4'h5, 8'd255, 1'b0);
    key(4'hF, 8'd255, 1'b1);
    key(4'h7, 8'd7, 1'b0);
    key(4'hF, 8'd7, 1'b1);
    key(4'h3, 8'd3, 1'b0);
    key(4'h0, 8'd30, 1'b0);
    key(4'h0, 8'd255, 1'b0);
    key(4'h9, 8'd255, 1'b0);
    key(4'hA, 8'd255, 1'b0);

    start = pulse_cnt;
    @(negedge Clk);
    glitch = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    glitch = 1'b0;
    repeat (40) @(posedge Clk);
    @(negedge Clk);
    check("glitch_no_pulse", 32'(pulse_cnt), 32'(start));
    check("glitch_state", 32'(kif.scan_state), 32'(SCAN));
    c0 = kif.Columnas;
    repeat (4) @(negedge Clk);
    check("scan_resumes", 32'(kif.Columnas != c0), 32'd1);

    key(4'hE, 8'd0, 1'b0);
    key(4'h4, 8'd4, 1'b0);
    key(4'h2, 8'd42, 1'b0);
    key(4'hE, 8'd0, 1'b0);
    key(4'h9, 8'd9, 1'b0);

    start    = pulse_cnt;
    key_row  = 2'd1;
    key_col  = 2'd1;
    key_down = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (kif.scan_state == DEB_PRESS) break;
      @(negedge Clk);
    end
    check("reach_deb_press", 32'(kif.scan_state), 32'(DEB_PRESS));
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check("midrst_columnas", 32'(kif.Columnas),   32'h0000000E);
    check("midrst_numero",   32'(kif.Numero),     32'd0);
    check("midrst_state",    32'(kif.scan_state), 32'(SCAN));
    check("midrst_tecla",    32'(kif.Tecla),      32'd0);
    key_down = 1'b0;
    Rst = 1'b0;
    repeat (30) @(posedge Clk);
    check("midrst_no_pulse", 32'(pulse_cnt), 32'(start));

    start = pulse_cnt;
    base  = pulse_cycle.size();
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_q.push_back({4'h1, 8'd1, 1'b0});
    exp_q.push_back({4'h1, 8'd11, 1'b0});
    exp_q.push_back({4'h1, 8'd111, 1'b0});
    press(4'h1, 60);
    check("repeat_count", 32'(pulse_cnt - start), 32'd3);
    if (pulse_cycle.size() >= base + 3) begin
      check("repeat_delay",  32'(pulse_cycle[base + 1] - pulse_cycle[base]),     32'd40);
      check("repeat_period", 32'(pulse_cycle[base + 2] - pulse_cycle[base + 1]), 32'd16);
    end
`else
    exp_q.push_back({4'h1, 8'd1, 1'b0});
    press(4'h1, 60);
    check("single_pulse", 32'(pulse_cnt - start), 32'd1);
`endif

    repeat (4) @(negedge Clk);
    check("listo_total", 32'(listo_cnt), 32'd2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
